// File: rtl/code_lock_ctrl.sv
// Keypad code lock: digit entry, code check, timed unlock, code reprogramming and
// alarm with key lockout after repeated wrong codes.
//
// state     | meaning
// S_IDLE    | collecting digits for an unlock attempt
// S_CHECK   | one cycle comparing the entry buffer against the stored code
// S_OPEN    | bolt released, unlock timer running
// S_PROG    | collecting a new code, programming-window timer running
// S_LOCKOUT | alarm tripped, all keys ignored until the lockout timer runs out
module code_lock_ctrl #(
   parameter int DIGITS         = 4,
   parameter int DIGIT_W        = 4,
   parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
   parameter int MAX_FAIL       = 3,
   parameter int UNLOCK_CYCLES  = 8,
   parameter int LOCKOUT_CYCLES = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            key_valid_i,
   input  logic [DIGIT_W-1:0]              digit_i,
   input  logic                            key_enter_i,
   input  logic                            key_prog_i,
   output logic                            lock_open_o,
   output logic                            prog_mode_o,
   output logic                            alarm_o,
   output logic                            lockout_o,
   output logic [DIGITS-1:0]               led_progress_o,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count_o
);

   localparam int CODE_W = DIGITS * DIGIT_W;
   localparam int CNT_W  = $clog2(DIGITS + 1);
   localparam int FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int MAX_T  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int TMR_W  = $clog2(MAX_T + 1);

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
   localparam logic [TMR_W-1:0]  T_UNLOCK  = TMR_W'(UNLOCK_CYCLES);
   localparam logic [TMR_W-1:0]  T_LOCKOUT = TMR_W'(LOCKOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_OPEN,
      S_PROG,
      S_LOCKOUT
   } state_t;

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   buf_q, buf_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [FAIL_W-1:0]   fail_q, fail_d;
   logic                alarm_q, alarm_d;
   logic                lock_open_q, prog_mode_q, lockout_q;
   logic [DIGITS-1:0]   led_q, led_d;

   logic                full;
   logic                tmr_last;
   logic [TMR_W-1:0]    timer_dec;
   logic [FAIL_W-1:0]   fail_inc;
   logic [CODE_W-1:0]   buf_shifted;

   assign full        = (cnt_q == CNT_FULL);
   // Terminal count at 1 so a window loaded with N lasts exactly N cycles.
   assign tmr_last    = (timer_q <= TMR_W'(1));
   assign timer_dec   = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;
   assign fail_inc    = (fail_q == FAIL_MAX) ? fail_q : fail_q + FAIL_W'(1);
   assign buf_shifted = (buf_q << DIGIT_W) | CODE_W'(digit_i);

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      code_d  = code_q;
      fail_d  = fail_q;
      alarm_d = alarm_q;
      led_d   = '0;

      case (state_q)
         S_IDLE: begin
            if (key_enter_i) begin
               if (full) begin
                  state_d = S_CHECK;
               end else begin
                  buf_d = '0;
                  cnt_d = '0;
               end
            end else if (key_valid_i && !full) begin
               buf_d = buf_shifted;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_CHECK: begin
            buf_d = '0;
            cnt_d = '0;
            if (buf_q == code_q) begin
               fail_d  = '0;
               alarm_d = 1'b0;
               timer_d = T_UNLOCK;
               state_d = S_OPEN;
            end else begin
               fail_d = fail_inc;
               if (fail_inc == FAIL_MAX) begin
                  alarm_d = 1'b1;
                  timer_d = T_LOCKOUT;
                  state_d = S_LOCKOUT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_OPEN: begin
            timer_d = timer_dec;
            if (key_prog_i) begin
               timer_d = T_UNLOCK;
               state_d = S_PROG;
            end else if (tmr_last) begin
               state_d = S_IDLE;
            end
         end

         S_PROG: begin
            timer_d = timer_dec;
            if (key_enter_i || tmr_last) begin
               if (key_enter_i && full) begin
                  code_d = buf_q;
               end
               buf_d   = '0;
               cnt_d   = '0;
               timer_d = '0;
               state_d = S_IDLE;
            end else if (key_valid_i && !full) begin
               buf_d = buf_shifted;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_LOCKOUT: begin
            timer_d = timer_dec;
            if (tmr_last) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_IDLE || state_d == S_PROG) begin
         for (int i = 0; i < DIGITS; i++) begin
            led_d[i] = (int'(cnt_d) > i);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         timer_q     <= '0;
         code_q      <= DEFAULT_CODE;
         fail_q      <= '0;
         alarm_q     <= 1'b0;
         lock_open_q <= 1'b0;
         prog_mode_q <= 1'b0;
         lockout_q   <= 1'b0;
         led_q       <= '0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         code_q      <= code_d;
         fail_q      <= fail_d;
         alarm_q     <= alarm_d;
         lock_open_q <= (state_d == S_OPEN);
         prog_mode_q <= (state_d == S_PROG);
         lockout_q   <= (state_d == S_LOCKOUT);
         led_q       <= led_d;
      end
   end

   assign lock_open_o    = lock_open_q;
   assign prog_mode_o    = prog_mode_q;
   assign alarm_o        = alarm_q;
   assign lockout_o      = lockout_q;
   assign led_progress_o = led_q;
   assign fail_count_o   = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: each stimulus cycle queues the expected
// output vector, an independent monitor pops and compares it after the clock edge.
module tb_code_lock_ctrl;

   typedef logic [9:0] vec_t;  // {lock_open, prog_mode, alarm, lockout, led[3:0], fail[1:0]}

   logic       clk;
   logic       rst;
   logic       key_valid;
   logic [3:0] digit;
   logic       key_enter;
   logic       key_prog;
   logic       lock_open;
   logic       prog_mode;
   logic       alarm;
   logic       lockout;
   logic [3:0] led_progress;
   logic [1:0] fail_count;

   vec_t  exp_q[$];
   string tag_q[$];
   int    n_vec  = 0;
   int    n_miss = 0;

   logic       e_al = 1'b0;
   logic [1:0] e_fc = 2'd0;

   code_lock_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .key_valid_i    (key_valid),
      .digit_i        (digit),
      .key_enter_i    (key_enter),
      .key_prog_i     (key_prog),
      .lock_open_o    (lock_open),
      .prog_mode_o    (prog_mode),
      .alarm_o        (alarm),
      .lockout_o      (lockout),
      .led_progress_o (led_progress),
      .fail_count_o   (fail_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t ev(input logic lo, input logic pm, input logic al, input logic lk,
                               input logic [3:0] led, input logic [1:0] fc);
      return {lo, pm, al, lk, led, fc};
   endfunction

   function automatic logic [3:0] therm(input int k);
      case (k)
         0:       return 4'b0000;
         1:       return 4'b0001;
         2:       return 4'b0011;
         3:       return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   // One clock of stimulus; x is the output vector expected after the next rising edge.
   task automatic cyc(input logic v, input logic [3:0] d, input logic e, input logic p,
                      input logic r, input vec_t x, input string tag);
      @(negedge clk);
      key_valid = v;
      digit     = d;
      key_enter = e;
      key_prog  = p;
      rst       = r;
      exp_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   task automatic do_reset(input string tag);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 0, 4'b0000, 2'd0), tag);
      e_al = 1'b0;
      e_fc = 2'd0;
   endtask

   task automatic keys(input logic [15:0] code, input int n, input logic pm);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, code[15-4*i -: 4], 1'b0, 1'b0, 1'b0,
             ev(0, pm, e_al, 0, therm(i + 1), e_fc), $sformatf("digit%0d", i + 1));
      end
   endtask

   // Enter on a correct full buffer: CHECK, then 8 open cycles, optionally cut
   // short by key_prog or rst in open cycle prog_at / rst_at.
   task automatic submit_ok(input int prog_at, input int rst_at);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, ev(0, 0, e_al, 0, 4'b0000, e_fc), "check_ok");
      e_al = 1'b0;
      e_fc = 2'd0;
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, ev(1, 0, 0, 0, 4'b0000, 2'd0), "open1");
      for (int i = 1; i <= 8; i++) begin
         if (i == prog_at) begin
            cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, ev(0, 1, 0, 0, 4'b0000, 2'd0), "prog_enter");
            return;
         end
         if (i == rst_at) begin
            do_reset("rst_open");
            return;
         end
         if (i < 8) begin
            cyc((i == 2), 4'h7, (i == 5), 1'b0, 1'b0, ev(1, 0, 0, 0, 4'b0000, 2'd0),
                $sformatf("open%0d", i + 1));
         end else begin
            cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 4'b0000, 2'd0), "closed");
         end
      end
   endtask

   // Enter on a wrong full buffer; new_fc is the hand-computed resulting count.
   task automatic submit_fail(input logic [1:0] new_fc, input int rst_at);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, ev(0, 0, e_al, 0, 4'b0000, e_fc), "check_bad");
      e_fc = new_fc;
      if (new_fc != 2'd3) begin
         cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, ev(0, 0, e_al, 0, 4'b0000, e_fc), "fail_idle");
         return;
      end
      e_al = 1'b1;
      for (int j = 1; j <= 17; j++) begin
         if (j == rst_at) begin
            do_reset("rst_lockout");
            return;
         end
         cyc((j >= 2), 4'h1, (j == 8), (j == 9), 1'b0,
             ev(0, 0, 1, (j <= 16), 4'b0000, 2'd3), $sformatf("lockout%0d", j));
      end
   endtask

   initial begin : monitor
      vec_t  got_v;
      vec_t  x_v;
      string t_v;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            x_v   = exp_q.pop_front();
            t_v   = tag_q.pop_front();
            got_v = {lock_open, prog_mode, alarm, lockout, led_progress, fail_count};
            n_vec++;
            if (got_v !== x_v) begin
               n_miss++;
               $display("FAIL %s @%0t: got lo/pm/al/lk/led/fc=%b want %b", t_v, $time, got_v, x_v);
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1;
      key_valid = 1'b0;
      digit = 4'h0;
      key_enter = 1'b0;
      key_prog = 1'b0;

      do_reset("reset0");
      do_reset("reset1");

      // default code opens
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      // three wrong codes trip alarm and lockout; correct code clears it
      keys(16'h1235, 4, 1'b0);
      submit_fail(2'd1, 0);
      keys(16'h1235, 4, 1'b0);
      submit_fail(2'd2, 0);
      keys(16'h1235, 4, 1'b0);
      submit_fail(2'd3, 0);
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      // programming aborted by short enter
      keys(16'h1234, 4, 1'b0);
      submit_ok(3, 0);
      keys(16'h9800, 2, 1'b1);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 4'b0000, 2'd0), "prog_abort");
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      // programming aborted by timeout
      keys(16'h1234, 4, 1'b0);
      submit_ok(3, 0);
      for (int j = 1; j <= 8; j++) begin
         cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, ev(0, (j < 8), 0, 0, 4'b0000, 2'd0),
             $sformatf("prog_wait%0d", j));
      end
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      // fifth digit ignored
      keys(16'h1234, 4, 1'b0);
      cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 4'b1111, 2'd0), "digit5");
      submit_ok(0, 0);

      // key_valid with key_enter: digit dropped, short enter clears
      keys(16'h1234, 3, 1'b0);
      cyc(1'b1, 4'h4, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 4'b0000, 2'd0), "valid_enter");
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      // short enter keeps fail_count
      keys(16'h1235, 4, 1'b0);
      submit_fail(2'd1, 0);
      keys(16'h1234, 2, 1'b0);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 4'b0000, 2'd1), "short_enter");
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      // program 9876; old code fails, new one opens
      keys(16'h1234, 4, 1'b0);
      submit_ok(3, 0);
      keys(16'h9876, 4, 1'b1);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 0, 4'b0000, 2'd0), "prog_commit");
      keys(16'h1234, 4, 1'b0);
      submit_fail(2'd1, 0);
      keys(16'h9876, 4, 1'b0);
      submit_ok(0, 0);

      // reset mid-PROG restores the default code
      keys(16'h9876, 4, 1'b0);
      submit_ok(2, 0);
      keys(16'h1234, 2, 1'b1);
      do_reset("rst_prog");
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      // reset in the 4th open cycle
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 4);
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      // reset during lockout clears alarm and fail_count
      keys(16'h1235, 4, 1'b0);
      submit_fail(2'd1, 0);
      keys(16'h1235, 4, 1'b0);
      submit_fail(2'd2, 0);
      keys(16'h1235, 4, 1'b0);
      submit_fail(2'd3, 6);
      keys(16'h1234, 4, 1'b0);
      submit_ok(0, 0);

      repeat (4) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d expected vectors left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
